quant_share_sched: RTL and testbench

- Time-multiplexes one quantizer instance across NUM_CH DEM-DAC channels.
- Round-robin arbitration between channel sample requesters, using valid/ready handshakes.
- Drives the quantizer's x/ntf inputs. Keeps a per-channel error-feedback memory, so the first-order NTF term fed back is that channel's last clamped quantization error.
- Returns the quantized level per channel over a valid/ready result port. Sits between the channel sample sources and the shared quantizer.

---
 rtl/lib_switchblock_pkg.sv | 6 +
 rtl/quant_share_sched.sv | 135 +++++++++++++
 tb/tb_quant_share_sched.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lib_switchblock_pkg.sv
// Shared datapath constants for the switch-block DEM quantizer path.
package lib_switchblock_pkg;
  localparam int INPUT_WIDTH = 16;
  localparam int QUANT_STEP  = 256;
  localparam int MAX_LEVEL   = 15;
endpackage

// File: rtl/quant_share_sched.sv
// Round-robin sharing of one registered quantizer across NUM_CH channels with per-channel error feedback.
// Result valid two edges after accept and held until out_ready_i; no new grant while a transaction is in flight.
module quant_share_sched
  import lib_switchblock_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = $clog2(NUM_CH),
  parameter int ERR_LIM = QUANT_STEP
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          clear_err_i,
  input  logic [NUM_CH-1:0]             ch_en_i,
  input  logic [NUM_CH-1:0]             ch_valid_i,
  input  logic [NUM_CH*INPUT_WIDTH-1:0] ch_sample_i,
  output logic [NUM_CH-1:0]             ch_ready_o,
  output logic [INPUT_WIDTH-1:0]        q_x_o,
  output logic [INPUT_WIDTH-1:0]        q_ntf_o,
  output logic                          q_rst_o,
  input  logic [INPUT_WIDTH-1:0]        q_level_i,
  input  logic [INPUT_WIDTH-1:0]        q_err_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [CH_W-1:0]               out_ch_o,
  output logic [INPUT_WIDTH-1:0]        out_level_o,
  output logic [INPUT_WIDTH-1:0]        out_err_o,
  output logic                          busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  localparam logic signed [INPUT_WIDTH-1:0] LIM_P = INPUT_WIDTH'(ERR_LIM);
  localparam logic signed [INPUT_WIDTH-1:0] LIM_N = -LIM_P;

  state_t                        r_state, w_state_nxt;
  logic [CH_W-1:0]               r_rr_ptr, r_ch, w_gnt_ch, w_rr_nxt;
  logic                          w_gnt_found, w_accept;
  logic [NUM_CH-1:0]             w_req, w_gnt_oh;
  logic [INPUT_WIDTH-1:0]        r_q_x, r_q_ntf, r_out_level, r_out_err;
  logic [CH_W-1:0]               r_out_ch;
  logic                          r_out_vld;
  logic [INPUT_WIDTH-1:0]        r_err_mem [NUM_CH];
  logic signed [INPUT_WIDTH-1:0] w_err_s, w_err_clamp;

  // First requesting channel at or above the round-robin pointer, wrapping.
  always_comb begin
    w_req       = ch_valid_i & ch_en_i & {NUM_CH{enable_i}};
    w_gnt_found = 1'b0;
    w_gnt_ch    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!w_gnt_found && w_req[(int'(r_rr_ptr) + i) % NUM_CH]) begin
        w_gnt_found = 1'b1;
        w_gnt_ch    = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_oh    = '0;
    case (r_state)
      S_IDLE: begin
        if (rst_ni && w_gnt_found) begin
          w_gnt_oh[w_gnt_ch] = 1'b1;
          w_state_nxt        = S_ISSUE;
        end
      end
      S_ISSUE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_RESP;
      S_RESP:    if (out_ready_i) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept = |(ch_valid_i & w_gnt_oh);
  assign w_rr_nxt = (w_gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_ch + 1'b1;

  always_comb begin
    w_err_s     = $signed(q_err_i);
    w_err_clamp = w_err_s;
    if (w_err_s > LIM_P) w_err_clamp = LIM_P;
    else if (w_err_s < LIM_N) w_err_clamp = LIM_N;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr    <= '0;
      r_ch        <= '0;
      r_q_x       <= '0;
      r_q_ntf     <= '0;
      r_out_vld   <= 1'b0;
      r_out_ch    <= '0;
      r_out_level <= '0;
      r_out_err   <= '0;
      for (int k = 0; k < NUM_CH; k++) r_err_mem[k] <= '0;
    end else begin
      if (w_accept) begin
        r_ch     <= w_gnt_ch;
        r_q_x    <= ch_sample_i[int'(w_gnt_ch)*INPUT_WIDTH +: INPUT_WIDTH];
        r_q_ntf  <= r_err_mem[w_gnt_ch];
        r_rr_ptr <= w_rr_nxt;
      end
      if (r_state == S_CAPTURE) begin
        r_out_vld   <= 1'b1;
        r_out_ch    <= r_ch;
        r_out_level <= q_level_i;
        r_out_err   <= w_err_clamp;
      end else if (r_state == S_RESP && out_ready_i) begin
        r_out_vld <= 1'b0;
      end
      // A coincident clear overrides the capture write-back.
      for (int k = 0; k < NUM_CH; k++) begin
        if (clear_err_i)                                  r_err_mem[k] <= '0;
        else if (r_state == S_CAPTURE && r_ch == CH_W'(k)) r_err_mem[k] <= w_err_clamp;
      end
    end
  end

  assign ch_ready_o  = w_gnt_oh;
  assign q_x_o       = r_q_x;
  assign q_ntf_o     = r_q_ntf;
  assign q_rst_o     = ~rst_ni;
  assign out_valid_o = r_out_vld;
  assign out_ch_o    = r_out_ch;
  assign out_level_o = r_out_level;
  assign out_err_o   = r_out_err;
  assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_quant_share_sched.sv
// Bench for quant_share_sched: a transaction-level model checked every cycle plus directed literal checks.
module tb_quant_share_sched;
  localparam int W = 16, N = 4, LIM = 256, STEP = 256, MAXL = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, enable, clear_err, out_ready, q_rst, out_valid, busy;
  logic [N-1:0]   ch_en, ch_valid, ch_ready;
  logic [N*W-1:0] ch_sample;
  logic [W-1:0]   q_x, q_ntf, q_level, q_err, out_level, out_err;
  logic [1:0]     out_ch;
  logic [W-1:0]   qz_level, qz_err, ovr_val;
  logic           ovr_en;

  int n_vec = 0, n_err = 0;
  bit chk_en = 0;

  quant_share_sched dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_err_i(clear_err),
    .ch_en_i(ch_en), .ch_valid_i(ch_valid), .ch_sample_i(ch_sample), .ch_ready_o(ch_ready),
    .q_x_o(q_x), .q_ntf_o(q_ntf), .q_rst_o(q_rst), .q_level_i(q_level), .q_err_i(q_err),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_ch_o(out_ch),
    .out_level_o(out_level), .out_err_o(out_err), .busy_o(busy)
  );

  // Quantizer: v = x/2 + ntf, rounded to nearest step, level clamped to +-MAXL.
  function automatic int q_lvl(input int x, input int ntf);
    int v, l;
    v = (x >>> 1) + ntf;
    l = (v + STEP/2) >>> 8;
    if (l > MAXL) l = MAXL;
    if (l < -MAXL) l = -MAXL;
    return l;
  endfunction

  function automatic int q_err_f(input int x, input int ntf);
    return ((x >>> 1) + ntf) - q_lvl(x, ntf) * STEP;
  endfunction

  always @(posedge clk) begin
    if (q_rst) begin
      qz_level <= '0;
      qz_err   <= '0;
    end else begin
      qz_level <= W'(q_lvl($signed(q_x), $signed(q_ntf)));
      qz_err   <= W'(q_err_f($signed(q_x), $signed(q_ntf)));
    end
  end
  assign q_level = qz_level;
  assign q_err   = ovr_en ? ovr_val : qz_err;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int rr);
    for (int i = 0; i < N; i++) if (req[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  // Model: one transaction at a time, aged in cycles since its accept edge.
  bit m_busy = 0;
  int m_age = 0, m_ch = 0, m_x = 0, m_ntf = 0, m_rr = 0, m_lvl = 0, m_e = 0;
  int m_mem [N] = '{default: 0};

  always @(negedge clk) begin : cmp
    logic [N-1:0] exp_rdy;
    int g, e;
    if (chk_en) begin
      exp_rdy = '0;
      g = -1;
      if (!m_busy && rst_n) begin
        g = pick(ch_valid & ch_en & {N{enable}}, m_rr);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      check("ch_ready", int'(ch_ready), int'(exp_rdy));
      check("busy", int'(busy), int'(m_busy));
      check("q_rst", int'(q_rst), int'(!rst_n));
      check("out_valid", int'(out_valid), int'(m_busy && m_age == 3));
      if (m_busy && (m_age == 1 || m_age == 2)) begin
        check("q_x", int'($signed(q_x)), m_x);
        check("q_ntf", int'($signed(q_ntf)), m_ntf);
      end
      if (m_busy && m_age == 3) begin
        check("out_ch", int'(out_ch), m_ch);
        check("out_level", int'($signed(out_level)), m_lvl);
        check("out_err", int'($signed(out_err)), m_e);
      end
      if (!rst_n) begin
        m_busy = 0; m_age = 0; m_rr = 0;
        for (int k = 0; k < N; k++) m_mem[k] = 0;
      end else begin
        if (!m_busy) begin
          if (g >= 0) begin
            m_busy = 1; m_age = 1; m_ch = g;
            m_x = $signed(ch_sample[g*W +: W]);
            m_ntf = m_mem[g];
            m_rr = (g + 1) % N;
          end
        end else if (m_age == 1) begin
          m_age = 2;
        end else if (m_age == 2) begin
          m_lvl = q_lvl(m_x, m_ntf);
          e = ovr_en ? int'($signed(ovr_val)) : q_err_f(m_x, m_ntf);
          if (e > LIM) e = LIM;
          if (e < -LIM) e = -LIM;
          m_e = e;
          m_mem[m_ch] = e;
          m_age = 3;
        end else if (out_ready) begin
          m_busy = 0; m_age = 0;
        end
        if (clear_err) for (int k = 0; k < N; k++) m_mem[k] = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_sample(input int ch, input int val);
    ch_sample[ch*W +: W] = W'(val);
  endtask

  // Returns one step after the accepting edge (ISSUE cycle).
  task automatic send(input int ch, input int smp);
    bit got;
    got = 0;
    set_sample(ch, smp);
    ch_valid = N'(1 << ch);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ch_ready[ch]) got = 1;
    end
    check("send_grant", int'(got), 1);
    step();
    ch_valid = '0;
  endtask

  task automatic wait_vld();
    bit got;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1;
    end
    check("wait_valid", int'(got), 1);
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    check("wait_idle", int'(got), 1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int g_ch[$];
    int g_cyc[$];
    int n_g1, n_tot;
    rst_n = 0; enable = 1; clear_err = 0; out_ready = 1; ch_en = '1; ch_valid = '1;
    ch_sample = '0; ovr_en = 0; ovr_val = '0;

    // Reset held 3 cycles with all channels requesting
    step();
    chk_en = 1;
    step(); step();
    @(negedge clk);
    check("rst_ch_ready", int'(ch_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_q_rst", int'(q_rst), 1);
    step();

    // Round robin with all channels valid
    set_sample(0, 1000); set_sample(1, -700); set_sample(2, 3000); set_sample(3, -4000);
    rst_n = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (|ch_ready) begin
        g_ch.push_back($clog2(ch_ready));
        g_cyc.push_back(c);
      end
    end
    step();
    ch_valid = '0;
    check("rr_grant_count", g_ch.size(), 5);
    for (int i = 0; i < g_ch.size() && i < 5; i++) begin
      check("rr_order", g_ch[i], i % N);
      check("rr_spacing", g_cyc[i], 4 * i);
    end
    wait_idle();
    rst_n = 0;
    step();
    rst_n = 1;

    // Single channel feedback: 1000 twice on ch0
    send(0, 1000);
    @(negedge clk);
    check("fb1_ntf", int'($signed(q_ntf)), 0);
    check("fb1_issue_vld", int'(out_valid), 0);
    @(negedge clk);
    check("fb1_capt_vld", int'(out_valid), 0);
    @(negedge clk);
    check("fb1_resp_vld", int'(out_valid), 1);
    check("fb1_level", int'($signed(out_level)), 2);
    check("fb1_err", int'($signed(out_err)), -12);
    step();
    send(0, 1000);
    @(negedge clk);
    check("fb2_ntf", int'($signed(q_ntf)), -12);
    wait_vld();
    check("fb2_level", int'($signed(out_level)), 2);
    check("fb2_err", int'($signed(out_err)), -24);
    step();

    // Clear coincident with CAPTURE: output keeps e, memory cleared
    send(0, 1000);
    step();
    clear_err = 1;
    step();
    clear_err = 0;
    @(negedge clk);
    check("clr_out_err", int'($signed(out_err)), -36);
    step();
    send(0, 1000);
    @(negedge clk);
    check("clr_next_ntf", int'($signed(q_ntf)), 0);
    wait_idle();

    // Clamp of stored error
    ovr_en = 1; ovr_val = W'(300);
    send(2, 0);
    wait_vld();
    check("clamp_pos_err", int'($signed(out_err)), 256);
    step();
    ovr_en = 0;
    wait_idle();
    send(2, 0);
    ovr_en = 1; ovr_val = 16'h8000;
    @(negedge clk);
    check("clamp_pos_ntf", int'($signed(q_ntf)), 256);
    wait_vld();
    check("clamp_neg_err", int'($signed(out_err)), -256);
    step();
    ovr_en = 0;
    wait_idle();

    // Backpressure: result held, no grants
    out_ready = 0;
    send(3, 2000);
    wait_vld();
    step();
    ch_valid = '1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ch_ready", int'(ch_ready), 0);
      check("bp_valid", int'(out_valid), 1);
      check("bp_ch", int'(out_ch), 3);
      check("bp_level", int'($signed(out_level)), 4);
      check("bp_err", int'($signed(out_err)), -24);
    end
    step();
    out_ready = 1;
    ch_en = 4'b1101;

    // Masked channel 1 never granted
    n_g1 = 0; n_tot = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (ch_ready[1]) n_g1++;
      if (|ch_ready) n_tot++;
    end
    check("mask_ch1_grants", n_g1, 0);
    check("mask_total_grants", n_tot, 6);
    step();
    ch_valid = '0;
    ch_en = '1;
    wait_idle();

    // Reset during RESP
    out_ready = 0;
    send(2, 1000);
    wait_vld();
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    @(negedge clk);
    check("rstresp_valid", int'(out_valid), 0);
    check("rstresp_busy", int'(busy), 0);
    step();
    out_ready = 1;
    send(2, 1000);
    @(negedge clk);
    check("rstresp_ntf", int'($signed(q_ntf)), 0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
